// File: rtl/counter_sweep_ctrl.sv
// Sequencing controller for a bounded W-bit up/down count: one-shot or ping-pong sweeps between lo and hi.
// Optional hold input is built only when SWEEP_CTRL_HOLD_EN is defined.
module counter_sweep_ctrl #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  input  logic [3:0]   sweeps,
  input  logic         abort,
`ifdef SWEEP_CTRL_HOLD_EN
  input  logic         hold,
`endif
  output logic [W-1:0] q,
  output logic         dir,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DOWN, ST_DONE} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [3:0]   sweeps_q, sweeps_d;
  logic [3:0]   sweep_cnt_q, sweep_cnt_d;
  logic         pingpong_q, pingpong_d;
  logic         dir_q, dir_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         freeze;

`ifdef SWEEP_CTRL_HOLD_EN
  assign freeze = hold;
`else
  assign freeze = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets its default first so no path leaves one unassigned and infers a latch.
    state_d     = state_q;
    count_d     = count_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    sweeps_d    = sweeps_q;
    sweep_cnt_d = sweep_cnt_q;
    pingpong_d  = pingpong_q;
    dir_d       = dir_q;
    err_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (lo > hi) begin
            err_d = 1'b1;
          end else begin
            lo_d        = lo;
            hi_d        = hi;
            sweeps_d    = sweeps;
            sweep_cnt_d = '0;
            pingpong_d  = (mode == 2'b10);
            if (mode == 2'b01) begin
              count_d = hi;
              dir_d   = 1'b1;
              state_d = ST_DOWN;
            end else begin
              count_d = lo;
              dir_d   = 1'b0;
              state_d = ST_UP;
            end
          end
        end
      end

      ST_UP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!freeze) begin
          if (count_q != hi_q) begin
            count_d = count_q + 1'b1;
          end else if (!pingpong_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DOWN;
            dir_d   = 1'b1;
            if (lo_q != hi_q) count_d = count_q - 1'b1;
          end
        end
      end

      ST_DOWN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!freeze) begin
          if (count_q != lo_q) begin
            count_d = count_q - 1'b1;
          end else if (!pingpong_q) begin
            state_d = ST_DONE;
          end else begin
            // One round trip ends at the bottom; sweeps of 0 means run until aborted.
            sweep_cnt_d = sweep_cnt_q + 4'd1;
            if (sweeps_q != 4'd0 && sweep_cnt_d == sweeps_q) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_UP;
              dir_d   = 1'b0;
              if (lo_q != hi_q) count_d = count_q + 1'b1;
            end
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_UP) || (state_d == ST_DOWN);
    done_d = (state_d == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      sweeps_q    <= '0;
      sweep_cnt_q <= '0;
      pingpong_q  <= 1'b0;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      sweeps_q    <= sweeps_d;
      sweep_cnt_q <= sweep_cnt_d;
      pingpong_q  <= pingpong_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign q    = count_q;
  assign dir  = dir_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
